// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks the PC through four byte addresses, assembles a
// big-endian 32-bit instruction, hands it downstream, then issues one PC strobe.
module instr_fetch_seq #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [5:0]  JUMP_OP     = 6'b000010,
  parameter logic [5:0]  BEQ_OP      = 6'b000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_data,
  input  logic        instr_ready,
  input  logic        branch_eq,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        update_lsbs,
  output logic        update_msbs,
  output logic        jump,
  output logic [5:0]  jump_destination,
  output logic        branch,
  output logic [5:0]  branch_offset
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_WAIT,
    S_CAPTURE,
    S_ADV,
    S_HOLD,
    S_STEP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] asm_q, asm_n;
  logic [31:0] instr_n;
  logic        valid_n, lsbs_n, msbs_n, jump_n, branch_n;
  logic [5:0]  dest_n, off_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_WAIT;
      count            <= WAIT_INIT;
      idx              <= 2'd0;
      asm_q            <= 32'd0;
      instr            <= 32'd0;
      instr_valid      <= 1'b0;
      update_lsbs      <= 1'b0;
      update_msbs      <= 1'b0;
      jump             <= 1'b0;
      branch           <= 1'b0;
      jump_destination <= 6'd0;
      branch_offset    <= 6'd0;
    end else begin
      state            <= state_n;
      count            <= count_n;
      idx              <= idx_n;
      asm_q            <= asm_n;
      instr            <= instr_n;
      instr_valid      <= valid_n;
      update_lsbs      <= lsbs_n;
      update_msbs      <= msbs_n;
      jump             <= jump_n;
      branch           <= branch_n;
      jump_destination <= dest_n;
      branch_offset    <= off_n;
    end
  end

  // Strobes are computed one state early so they are registered for the cycle they belong to.
  always_comb begin
    state_n  = state;
    count_n  = count;
    idx_n    = idx;
    asm_n    = asm_q;
    instr_n  = instr;
    valid_n  = instr_valid;
    lsbs_n   = 1'b0;
    msbs_n   = 1'b0;
    jump_n   = 1'b0;
    branch_n = 1'b0;
    dest_n   = 6'd0;
    off_n    = 6'd0;
    case (state)
      S_WAIT: begin
        count_n = count - 4'd1;
        if (count <= 4'd1) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        case (idx)
          2'd0:    asm_n[31:24] = mem_data;
          2'd1:    asm_n[23:16] = mem_data;
          2'd2:    asm_n[15:8]  = mem_data;
          default: asm_n[7:0]   = mem_data;
        endcase
        if (idx != 2'd3) begin
          idx_n   = idx + 2'd1;
          lsbs_n  = 1'b1;
          state_n = S_ADV;
        end else begin
          instr_n = {asm_q[31:8], mem_data};
          valid_n = 1'b1;
          idx_n   = 2'd0;
          state_n = S_HOLD;
        end
      end
      S_ADV: begin
        count_n = WAIT_INIT;
        state_n = S_WAIT;
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_n = 1'b0;
          state_n = S_STEP;
          if (instr[31:26] == JUMP_OP) begin
            jump_n = 1'b1;
            dest_n = instr[5:0];
          end else if (instr[31:26] == BEQ_OP && branch_eq) begin
            branch_n = 1'b1;
            off_n    = instr[5:0];
          end else begin
            msbs_n = 1'b1;
          end
        end
      end
      S_STEP: begin
        count_n = WAIT_INIT;
        state_n = S_WAIT;
      end
      default: state_n = S_WAIT;
    endcase
  end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer that drives the program counter's strobes and consumes the byte-wide instruction memory it addresses. For each instruction it:
- steps through the 4 byte addresses with `update_lsbs`;
- assembles a 32-bit big-endian instruction and presents it downstream with a valid/ready handshake;
- on acceptance, issues exactly one of `update_msbs`, `jump` or `branch`, based on the opcode.

It sits between instruction memory and the decode/execute logic.

## Interface
- `WAIT_CYCLES`, 3: cycles between a PC strobe and the byte capture. Range 1..15. 3 covers 1 PC input register + 1 `mem_addr` register + 1 synchronous memory read.
- `JUMP_OP`, 6'b000010: opcode for an unconditional jump.
- `BEQ_OP`, 6'b000100: opcode for branch-if-equal.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_data`  in  8  byte read from instruction memory at the PC's current `mem_addr`.
- `instr_ready`  in  1  downstream accepts `instr` when high together with `instr_valid`.
- `branch_eq`  in  1  datapath equality result; sampled in the acceptance cycle.
- `instr`  out  32  assembled instruction. Byte at `mem_addr[1:0]`=0 lands in [31:24].
- `instr_valid`  out  1  `instr` is complete and held stable.
- `update_lsbs`  out  1  one-cycle pulse: advance to the next byte.
- `update_msbs`  out  1  one-cycle pulse: advance to the next instruction.
- `jump`  out  1  one-cycle pulse: jump to `jump_destination`.
- `jump_destination`  out  6  `instr[5:0]` during the `jump` pulse, otherwise 0.
- `branch`  out  1  one-cycle pulse: branch by `branch_offset`.
- `branch_offset`  out  6  `instr[5:0]` during the `branch` pulse, otherwise 0.

## Operation
- All outputs are registered. The reset value of every output is 0.
- Reset puts the FSM in WAIT with count = `WAIT_CYCLES`, byte index = 0, assembly register = 0. The PC is reset at the same time by the system.
- FSM states:
  - WAIT: decrement the counter; at 1, go to CAPTURE.
  - CAPTURE: shift `mem_data` into the byte lane selected by the index.
    - If index < 3: index++, go to ADV.
    - If index = 3: load `instr` from the assembled value, set `instr_valid`, index = 0, go to HOLD.
  - ADV: `update_lsbs`=1 for this cycle; reload counter to `WAIT_CYCLES`; go to WAIT.
  - HOLD: `instr_valid`=1 and `instr` frozen.
    - When `instr_ready`=1: clear `instr_valid` on the next edge, latch the strobe choice, go to STEP.
  - STEP: drive exactly one strobe for one cycle; reload the counter; go to WAIT.
- Strobe choice, using opcode `instr[31:26]`:
  - = `JUMP_OP` → `jump`.
  - = `BEQ_OP` and `branch_eq`=1 in the acceptance cycle → `branch`.
  - Otherwise → `update_msbs`. This includes BEQ not taken.
- `update_lsbs` is never issued after byte 3. The PC's 2-bit LSB field never wraps through this block.
- At most one of `update_lsbs`, `update_msbs`, `jump`, `branch` is high in any cycle.
- `instr` changes only on entry to HOLD. It keeps its last value while the next instruction is fetched.
- Reset mid-operation, in any state, takes effect on the next edge. A partially assembled instruction is discarded, and fetch restarts from byte 0 using the post-reset timing.

## Timing
- Cycle 0 is the first cycle with `rst`=0.
- Byte captures (sample taken on the edge ending the cycle):
  - byte 0: cycle W
  - byte 1: cycle 2W+2
  - byte 2: cycle 3W+4
  - byte 3: cycle 4W+6
- `update_lsbs` pulses at cycles W+1, 2W+3 and 3W+5.
- `instr_valid` rises at cycle 4W+7.
- After acceptance in cycle A:
  - strobe in cycle A+1;
  - byte 0 of the next instruction captured in cycle A+W+2;
  - next `instr_valid` at A+4W+9.
- Minimum period is 4W+9 cycles per instruction (21 for W=3).
- `instr_valid` stays high while `instr_ready`=0. There is no timeout.

## Test plan
- Reset, W=3, memory bytes 0x8C,0x22,0x00,0x04 at addresses 0..3 → `update_lsbs` pulses at cycles 4, 9, 14; `instr_valid` rises at cycle 19 with `instr`=0x8C220004; no other strobes.
- Accept 0x8C220004 in cycle 19 → `update_msbs` high only in cycle 20; next byte 0 sampled in cycle 24; `instr_valid` low from cycle 20.
- Instruction 0x08000005 accepted → `jump`=1 and `jump_destination`=6'd5 for one cycle; `update_msbs`=0; `jump_destination` returns to 0 the next cycle.
- Instruction 0x10000003 with `branch_eq`=1 → `branch`=1, `branch_offset`=3. Repeat with `branch_eq`=0 → `update_msbs` pulse, `branch`=0.
- Hold `instr_ready`=0 for 10 cycles after `instr_valid` → `instr_valid` stays 1, `instr` is unchanged, all strobes stay 0; strobe appears exactly 1 cycle after `instr_ready` rises.
- Assert `rst` in the WAIT after byte 2 → all outputs 0 on the next edge; after release, `update_lsbs` appears at cycle 4 and `instr_valid` at cycle 19, with bytes re-read from address 0.
